// File: rtl/fir_decim_buffer_pkg.sv
// Shared widths and helpers for the post-FIR decimator and its output buffer.
package fir_decim_buffer_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAC_W   = 14;
  localparam int unsigned DROP_W   = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_decim_buffer_sync_fifo.sv
// First-word fall-through synchronous FIFO with a registered head word.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_dout;
  logic             r_full;
  logic             r_empty;
  logic             r_valid;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] w_dout_nxt;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_pop       = i_pop && !r_empty;
    w_push      = i_push && (!r_full || w_pop);
    w_level_nxt = r_level;
    w_dout_nxt  = r_dout;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
    if (r_empty) begin
      if (w_push) w_dout_nxt = i_din;
    end else if (w_pop) begin
      if (r_level == LW'(1)) begin
        if (w_push) w_dout_nxt = i_din;
      end else begin
        w_dout_nxt = r_mem[r_rd_ptr + AW'(1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_dout  <= w_dout_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
      r_valid <= (w_level_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/fir_decim_buffer.sv
// Discards the FIR priming samples, keeps every DECIM-th sample and buffers it for the consumer.
module fir_decim_buffer
  import fir_decim_buffer_pkg::*;
#(
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PRIME = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SAMPLE_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SAMPLE_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int unsigned PRIME_W = cnt_width(PRIME + 1);
  localparam int unsigned PHASE_W = cnt_width(DECIM);

  logic [PRIME_W-1:0] r_prime_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop_count;

  logic w_primed;
  logic w_keep;
  logic w_pop;
  logic w_drop;
  logic w_full;
  logic w_empty;

  always_comb begin
    w_primed = (r_prime_cnt == PRIME_W'(PRIME));
    w_keep   = in_valid && w_primed && (r_phase == '0);
    w_pop    = out_ready && !w_empty;
    w_drop   = w_keep && w_full && !w_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prime_cnt  <= '0;
      r_phase      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (in_valid && !w_primed) r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
      if (in_valid && w_primed) begin
        r_phase <= (r_phase == PHASE_W'(DECIM - 1)) ? '0 : r_phase + PHASE_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep),
    .i_din   (in_data),
    .i_pop   (w_pop),
    .o_dout  (out_data),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: default, DECIM=1/PRIME=0 and DECIM=2/PRIME=0 instances.
module tb_fir_decim_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_iv, a_rdy, a_ov, a_of;
  logic [15:0] a_d, a_od, a_dc;
  logic [3:0]  a_lvl;

  logic        b_iv, b_rdy, b_ov, b_of;
  logic [15:0] b_d, b_od, b_dc;
  logic [3:0]  b_lvl;

  logic        c_iv, c_rdy, c_ov, c_of;
  logic [15:0] c_d, c_od, c_dc;
  logic [3:0]  c_lvl;

  int errors = 0;
  int checks = 0;

  fir_decim_buffer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_rdy), .out_data(a_od),
    .fifo_level(a_lvl), .overflow(a_of), .drop_count(a_dc)
  );

  fir_decim_buffer #(.DECIM(1), .DEPTH(8), .PRIME(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_rdy), .out_data(b_od),
    .fifo_level(b_lvl), .overflow(b_of), .drop_count(b_dc)
  );

  fir_decim_buffer #(.DECIM(2), .DEPTH(8), .PRIME(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_data(c_d),
    .out_valid(c_ov), .out_ready(c_rdy), .out_data(c_od),
    .fifo_level(c_lvl), .overflow(c_of), .drop_count(c_dc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_v;
    rst_n = 1'b0;
    a_iv = 1'b0; a_rdy = 1'b0; a_d = '0;
    b_iv = 1'b0; b_rdy = 1'b0; b_d = '0;
    c_iv = 1'b0; c_rdy = 1'b0; c_d = '0;
    tick();

    // Reset state
    chk("rst_valid", a_ov, 0);
    chk("rst_level", a_lvl, 0);
    chk("rst_overflow", a_of, 0);
    chk("rst_drop", a_dc, 0);
    chk("rst_data", a_od, 0);

    // DECIM=1/PRIME=0 pass-through and DECIM=2 with gapped in_valid
    rst_n = 1'b1;
    b_rdy = 1'b1;
    c_rdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      b_iv = 1'b1;
      b_d  = 16'(100 + t);
      c_iv = (t % 2 == 0);
      c_d  = 16'(200 + t);
      tick();
      chk("b_valid", b_ov, 1);
      chk("b_data", b_od, 100 + t);
      chk("b_level", b_lvl, 1);
      if (t % 4 == 0) begin
        chk("c_valid", c_ov, 1);
        chk("c_data", c_od, 200 + t);
      end else begin
        chk("c_valid", c_ov, 0);
      end
    end
    b_iv = 1'b0;
    c_iv = 1'b0;

    // Priming and decimation by 4 with a ramp input
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_rdy = 1'b1;
    a_iv  = 1'b1;
    for (int idx = 0; idx <= 26; idx++) begin
      a_d = 16'(idx);
      tick();
      exp_v = (idx >= 14) && ((idx - 14) % 4 == 0);
      chk("a_prime_valid", a_ov, exp_v);
      if (exp_v) chk("a_prime_data", a_od, idx);
    end

    // Fill to full without a consumer, then push and pop together while full
    rst_n = 1'b0;
    a_d   = 16'hDEAD;
    tick();
    rst_n = 1'b1;
    a_rdy = 1'b0;
    for (int idx = 0; idx <= 45; idx++) begin
      a_d = 16'(idx);
      tick();
      if (idx == 42) begin
        chk("a_full_level", a_lvl, 8);
        chk("a_full_overflow", a_of, 0);
      end
    end
    a_rdy = 1'b1;
    a_d   = 16'(46);
    tick();
    chk("a_fullpp_level", a_lvl, 8);
    chk("a_fullpp_overflow", a_of, 0);
    chk("a_fullpp_drop", a_dc, 0);
    chk("a_fullpp_head", a_od, 18);

    // Push into a full FIFO with no pop is dropped
    a_rdy = 1'b0;
    for (int idx = 47; idx <= 50; idx++) begin
      a_d = 16'(idx);
      tick();
    end
    chk("a_drop_overflow", a_of, 1);
    chk("a_drop_count", a_dc, 1);
    chk("a_drop_level", a_lvl, 8);
    chk("a_drop_head", a_od, 18);

    // Drain in FIFO order; the sample pushed while full comes out last
    a_iv  = 1'b0;
    a_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("a_drain_valid", a_ov, 1);
      chk("a_drain_data", a_od, 18 + 4 * k);
      tick();
    end
    chk("a_drained_valid", a_ov, 0);
    chk("a_drained_level", a_lvl, 0);
    chk("a_sticky_overflow", a_of, 1);
    chk("a_sticky_drop", a_dc, 1);

    // Reset with 5 entries buffered and overflow set
    a_iv  = 1'b1;
    a_rdy = 1'b0;
    for (int idx = 51; idx <= 70; idx++) begin
      a_d = 16'(idx);
      tick();
    end
    chk("a_five_level", a_lvl, 5);
    chk("a_five_overflow", a_of, 1);
    rst_n = 1'b0;
    a_d   = 16'h1234;
    tick();
    chk("a_mid_rst_valid", a_ov, 0);
    chk("a_mid_rst_level", a_lvl, 0);
    chk("a_mid_rst_overflow", a_of, 0);
    chk("a_mid_rst_drop", a_dc, 0);
    chk("a_mid_rst_data", a_od, 0);
    rst_n = 1'b1;
    a_rdy = 1'b1;
    for (int idx = 0; idx <= 14; idx++) begin
      a_d = 16'(idx);
      tick();
      chk("a_reprime_valid", a_ov, (idx == 14));
      if (idx == 14) chk("a_reprime_data", a_od, 14);
    end
    a_iv = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

Interface
REQ-001 Parameter DECIM, default 4: decimation factor; legal range 1..16.
REQ-002 Parameter DEPTH, default 8: output FIFO depth in entries; power of two, 2..64.
REQ-003 Parameter PRIME, default 14: number of valid input samples discarded after reset (FIR pipeline plus tap fill).
REQ-004 clk  input  1  100 MHz sampling clock, rising-edge.
REQ-005 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 in_valid  input  1  in_data carries a filtered sample this cycle.
REQ-007 in_data  input  16  signed filtered sample, 1.1.14.
REQ-008 out_valid  output  1  out_data holds the FIFO head.
REQ-009 out_ready  input  1  consumer accepts the head this cycle.
REQ-010 out_data  output  16  signed decimated sample, 1.1.14, passed through unchanged.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.
REQ-013 drop_count  output  16  number of dropped kept samples; saturates at 16'hFFFF.

Function
REQ-014 Prime counter counts in_valid cycles from 0 to PRIME; while it is below PRIME, samples are discarded and the phase counter holds at 0.
REQ-015 After priming, phase counter advances 0..DECIM-1 on each in_valid and wraps to 0; cycles without in_valid leave it unchanged.
REQ-016 A sample is kept when in_valid=1, priming is complete and phase=0, so samples 0, DECIM, 2*DECIM, ... after priming are kept.
REQ-017 DECIM=1 keeps every post-prime sample.
REQ-018 A kept sample is pushed into the FIFO in the same cycle and is visible on out_data/out_valid the next cycle when the FIFO was empty (latency 1, first-word fall-through).
REQ-019 A pop occurs when out_valid=1 and out_ready=1; out_data advances to the next entry the following cycle.
REQ-020 out_valid is 1 exactly when fifo_level is greater than 0; out_data is stable while out_valid=1 and out_ready=0.
REQ-021 When the FIFO is not full and a push and a pop coincide, both take effect and the level is unchanged.
REQ-022 When the FIFO is full and a push and a pop coincide, both take effect, with no drop and no overflow.
REQ-023 When the FIFO is full, a push occurs and there is no pop: the sample is dropped, overflow is set, drop_count increments (saturating), and FIFO contents are unchanged.
REQ-024 out_ready while the FIFO is empty has no effect.
REQ-025 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-026 FIFO ordering is strict first-in, first-out; data is never modified, rounded or saturated.

Reset
REQ-027 On a clk edge with rst_n=0, the following clear: prime counter, phase counter, pointers, fifo_level, overflow, drop_count and out_valid.
REQ-028 out_data resets to 16'h0000.
REQ-029 Reset asserted mid-operation discards all FIFO contents and restarts priming; in_valid during reset is ignored.
REQ-030 overflow and drop_count clear only on reset.

Structure
REQ-031 A shared package holds the sample width (16), the fractional-bit count (14) and the drop_count width (16).
REQ-032 The FIFO is implemented as one sub-module, sync_fifo, parameterised by width and depth, with push, pop, full, empty and level.
REQ-033 Prime and phase control remain in the top module.

Verification
REQ-034 rst_n low then high, in_valid=1 continuously with in_data = sample index (0,1,2,...) and out_ready=1 -> out_data sequence is 14, 18, 22, 26; the first out_valid occurs 15 cycles after reset release.
REQ-035 DECIM=1, PRIME=0, in_data ramp, out_ready=1 -> out_data equals in_data delayed by 1 cycle on every cycle.
REQ-036 out_ready=0 with continuous post-prime input, DECIM=4, DEPTH=8 -> fifo_level reaches 8 after 8 kept samples; the 9th is dropped, overflow=1, drop_count=1; after out_ready=1, the first 8 kept values are read in order.
REQ-037 FIFO full, with a kept push and out_ready=1 in the same cycle -> level stays 8, overflow stays 0, and the new sample appears last.
REQ-038 rst_n pulsed low for 1 cycle with the FIFO holding 5 entries and overflow=1 -> the next cycle shows out_valid=0, level=0, overflow=0, drop_count=0, and priming restarts (the next output is post-reset sample 14).
REQ-039 in_valid toggling 1,0,1,0 after priming with DECIM=2 -> kept samples are every 2nd valid sample, not every 2nd clock.
